// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and constants for the bus gate arbiter
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_t;
  localparam int NREQ = 4;
  localparam int IDX_ALU = 0;
  localparam int IDX_MDR = 1;
  localparam int IDX_PC = 2;
  localparam int IDX_MAR = 3;
  function automatic logic [NREQ-1:0] onehot(input logic [1:0] i);
    return NREQ'(1) << i;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: rotating-priority search starting at ptr, first high request wins
module rr_picker
  import bus_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            any,
  output logic [1:0]      idx
);
  logic [NREQ-1:0] rot;
  logic [1:0]      off;
  assign rot = NREQ'({req, req} >> ptr);
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign any = |req;
  assign idx = ptr + off;
endmodule

// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter: round-robin owner of the one-hot CPU bus-mux gate with burst cap and turnaround
module bus_gate_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_BURST  = 8,
  parameter int TURNAROUND = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  output logic [NREQ-1:0] gate,
  output logic [1:0]      grant_id,
  output logic            busy,
  output logic [NREQ-1:0] drop
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LIMIT = BW'(MAX_BURST - 1);
  localparam logic [1:0] TLOAD = 2'(TURNAROUND > 0 ? TURNAROUND - 1 : 0);
  arb_state_t    state;
  logic [1:0]    rr_ptr;
  logic [BW-1:0] beat_cnt;
  logic [1:0]    turn_cnt;
  logic          any;
  logic [1:0]    idx;
  logic          at_limit;
  logic          released;
  logic          leave;
  logic          arb;
  rr_picker u_pick (.req(req), .ptr(rr_ptr), .any(any), .idx(idx));
  // release wins over preemption; a lock sampled high on the limit edge blocks preemption
  always_comb begin
    at_limit = beat_cnt == LIMIT;
    released = !req[grant_id];
    leave    = state == GRANT && (released || (at_limit && !lock[grant_id] && |(req & ~gate)));
    arb      = state == IDLE || (state == TURN && turn_cnt == 2'd0) || (leave && TURNAROUND == 0);
  end
  // FSM, counters, round-robin pointer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gate     <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      drop     <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      drop <= (leave && !released) ? gate : '0;
      if (arb) begin
        state    <= any ? GRANT : IDLE;
        gate     <= any ? onehot(idx) : '0;
        busy     <= any;
        beat_cnt <= '0;
        if (any) begin
          grant_id <= idx;
          rr_ptr   <= idx + 2'd1;
        end
      end else if (leave) begin
        state    <= TURN;
        gate     <= '0;
        busy     <= 1'b0;
        turn_cnt <= TLOAD;
      end else if (state == GRANT && !at_limit) begin
        beat_cnt <= beat_cnt + 1'b1;
      end else if (state == TURN) begin
        turn_cnt <= turn_cnt - 2'd1;
      end
    end
  end
endmodule
